// File: rtl/tx_frame_stats.sv
// Frame statistics collector for the transmit byte stream (txd/tx_en).
// Delimits frames, keeps frame/byte/runt counters and exposes them as bus registers.
module tx_frame_stats #(
   parameter logic [15:0] BASE_ADDR = 16'h0010,
   parameter logic [15:0] MIN_LEN   = 16'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bus_cmd_valid,
   input  logic        bus_op,
   input  logic [15:0] bus_addr,
   input  logic [15:0] bus_wr_data,
   output logic [15:0] bus_rd_data,
   input  logic [7:0]  txd,
   input  logic        tx_en,
   output logic        frame_done
);

   typedef enum logic [1:0] {IDLE, IN_FRAME, SKIP} state_t;

   state_t      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [7:0]  sum_q, sum_d;
   logic        enable_q, enable_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] byte_cnt_q, byte_cnt_d;
   logic [15:0] last_len_q, last_len_d;
   logic [7:0]  last_sum_q, last_sum_d;
   logic [15:0] runt_cnt_q, runt_cnt_d;
   logic [15:0] rd_data_q, rd_data_d;
   logic        frame_done_q, frame_done_d;

   logic [15:0] offset;
   logic        in_range;
   logic        wr_ctrl;
   logic        commit;

   // Addresses below BASE_ADDR wrap to large offsets, so one compare covers both bounds.
   assign offset   = bus_addr - BASE_ADDR;
   assign in_range = (offset < 16'd6);
   assign wr_ctrl  = bus_cmd_valid && bus_op && (bus_addr == BASE_ADDR);

   always_comb begin
      // NOTE: every _d starts from its _q so no path through this block can infer a latch.
      state_d      = state_q;
      len_d        = len_q;
      sum_d        = sum_q;
      enable_d     = enable_q;
      frame_cnt_d  = frame_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      last_len_d   = last_len_q;
      last_sum_d   = last_sum_q;
      runt_cnt_d   = runt_cnt_q;
      rd_data_d    = rd_data_q;
      commit       = 1'b0;

      case (state_q)
         IDLE: begin
            if (tx_en) begin
               if (enable_q) begin
                  state_d = IN_FRAME;
                  len_d   = 16'd1;
                  sum_d   = txd;
               end else begin
                  state_d = SKIP;
               end
            end
         end
         IN_FRAME: begin
            // Enable is only consulted at frame start, so a started frame always completes.
            if (tx_en) begin
               if (len_q != 16'hFFFF) len_d = len_q + 16'd1;
               sum_d = sum_q + txd;
            end else begin
               commit  = 1'b1;
               state_d = IDLE;
            end
         end
         SKIP: begin
            if (!tx_en) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (commit) begin
         if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
         byte_cnt_d = byte_cnt_q + len_q;
         last_len_d = len_q;
         last_sum_d = sum_q;
         if ((len_q < MIN_LEN) && (runt_cnt_q != 16'hFFFF)) runt_cnt_d = runt_cnt_q + 16'd1;
      end
      frame_done_d = commit;

      // Clear is applied after commit so it wins when both land on the same edge.
      if (wr_ctrl) begin
         enable_d = bus_wr_data[0];
         if (bus_wr_data[1]) begin
            frame_cnt_d = '0;
            byte_cnt_d  = '0;
            last_len_d  = '0;
            last_sum_d  = '0;
            runt_cnt_d  = '0;
         end
      end

      if (bus_cmd_valid && !bus_op) begin
         rd_data_d = '0;
         if (in_range) begin
            case (offset[2:0])
               3'd0:    rd_data_d = {15'd0, enable_q};
               3'd1:    rd_data_d = frame_cnt_q;
               3'd2:    rd_data_d = byte_cnt_q;
               3'd3:    rd_data_d = last_len_q;
               3'd4:    rd_data_d = {8'h00, last_sum_q};
               3'd5:    rd_data_d = runt_cnt_q;
               default: rd_data_d = '0;
            endcase
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         len_q        <= '0;
         sum_q        <= '0;
         enable_q     <= 1'b1;
         frame_cnt_q  <= '0;
         byte_cnt_q   <= '0;
         last_len_q   <= '0;
         last_sum_q   <= '0;
         runt_cnt_q   <= '0;
         rd_data_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         sum_q        <= sum_d;
         enable_q     <= enable_d;
         frame_cnt_q  <= frame_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         last_len_q   <= last_len_d;
         last_sum_q   <= last_sum_d;
         runt_cnt_q   <= runt_cnt_d;
         rd_data_q    <= rd_data_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus_rd_data = rd_data_q;
   assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_tx_frame_stats.sv
// Directed bench for tx_frame_stats: bus register access and frame statistics.
// Inputs change and outputs are sampled on the falling edge.
module tb_tx_frame_stats;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        bus_cmd_valid;
   logic        bus_op;
   logic [15:0] bus_addr;
   logic [15:0] bus_wr_data;
   logic [15:0] bus_rd_data;
   logic [7:0]  txd;
   logic        tx_en;
   logic        frame_done;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int done_base;
   logic [15:0] rd;

   tx_frame_stats dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus_cmd_valid (bus_cmd_valid),
      .bus_op        (bus_op),
      .bus_addr      (bus_addr),
      .bus_wr_data   (bus_wr_data),
      .bus_rd_data   (bus_rd_data),
      .txd           (txd),
      .tx_en         (tx_en),
      .frame_done    (frame_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bus_read(input logic [15:0] addr, output logic [15:0] data);
      @(negedge clk);
      bus_cmd_valid = 1'b1; bus_op = 1'b0; bus_addr = addr;
      @(negedge clk);
      bus_cmd_valid = 1'b0;
      data = bus_rd_data;
   endtask

   task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
      @(negedge clk);
      bus_cmd_valid = 1'b1; bus_op = 1'b1; bus_addr = addr; bus_wr_data = data;
      @(negedge clk);
      bus_cmd_valid = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [15:0] addr, input logic [15:0] exp);
      logic [15:0] d;
      bus_read(addr, d);
      check(tag, d, exp);
   endtask

   // Byte i of the frame is bytes[8*i +: 8]; returns on the edge that drops tx_en.
   // With clr set, a CTRL=0x0003 write is driven in the same cycle as the terminating idle.
   task automatic send_frame(input logic [63:0] bytes, input int n, input bit clr);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tx_en = 1'b1; txd = bytes[8*i +: 8];
      end
      @(negedge clk);
      tx_en = 1'b0;
      if (clr) begin
         bus_cmd_valid = 1'b1; bus_op = 1'b1; bus_addr = 16'h0010; bus_wr_data = 16'h0003;
         @(negedge clk);
         bus_cmd_valid = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; bus_cmd_valid = 1'b0; bus_op = 1'b0; bus_addr = '0;
      bus_wr_data = '0; txd = '0; tx_en = 1'b0;
      idle(2);
      check("reset_rd_data", bus_rd_data, 16'h0000);
      check("reset_frame_done", {15'd0, frame_done}, 16'h0000);
      rst_n = 1'b1;

      // Reset values of the register map and an unmapped read.
      read_check("rst_ctrl",  16'h0010, 16'h0001);
      read_check("rst_frame", 16'h0011, 16'h0000);
      read_check("rst_byte",  16'h0012, 16'h0000);
      read_check("rst_len",   16'h0013, 16'h0000);
      read_check("rst_sum",   16'h0014, 16'h0000);
      read_check("rst_runt",  16'h0015, 16'h0000);
      read_check("unmapped_09", 16'h0009, 16'h0000);
      read_check("unmapped_16", 16'h0016, 16'h0000);

      // 5-byte frame 01..05, sum 0x0F.
      done_base = done_cnt;
      send_frame(64'h0000_0005_0403_0201, 5, 1'b0);
      idle(3);
      check("f1_done_pulses", 16'(done_cnt - done_base), 16'd1);
      read_check("f1_frame", 16'h0011, 16'd1);
      read_check("f1_byte",  16'h0012, 16'd5);
      read_check("f1_len",   16'h0013, 16'd5);
      read_check("f1_sum",   16'h0014, 16'h000F);
      read_check("f1_runt",  16'h0015, 16'd0);

      // Runt FF,02: sum wraps to 0x01.
      send_frame(64'h0000_0000_0000_02FF, 2, 1'b0);
      idle(3);
      read_check("runt_cnt",   16'h0015, 16'd1);
      read_check("runt_sum",   16'h0014, 16'h0001);
      read_check("runt_len",   16'h0013, 16'd2);
      read_check("runt_frame", 16'h0011, 16'd2);

      // Two 3-byte frames split by a single idle cycle.
      done_base = done_cnt;
      send_frame(64'h0000_0000_0030_2010, 3, 1'b0);
      send_frame(64'h0000_0000_0001_0101, 3, 1'b0);
      idle(3);
      check("split_done_pulses", 16'(done_cnt - done_base), 16'd2);
      read_check("split_frame", 16'h0011, 16'd4);
      read_check("split_byte",  16'h0012, 16'd13);
      read_check("split_len",   16'h0013, 16'd3);
      read_check("split_sum",   16'h0014, 16'h0003);
      read_check("split_runt",  16'h0015, 16'd3);

      // Disable mid 6-byte frame (bytes 1..6, sum 0x15): frame still counted, next one skipped.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         tx_en = 1'b1; txd = 8'(i + 1);
         bus_cmd_valid = (i == 2); bus_op = 1'b1; bus_addr = 16'h0010; bus_wr_data = 16'h0000;
      end
      @(negedge clk);
      tx_en = 1'b0; bus_cmd_valid = 1'b0;
      idle(2);
      send_frame(64'h0000_0000_0808_0808, 4, 1'b0);
      idle(3);
      read_check("dis_ctrl",  16'h0010, 16'h0000);
      read_check("dis_frame", 16'h0011, 16'd5);
      read_check("dis_len",   16'h0013, 16'd6);
      read_check("dis_sum",   16'h0014, 16'h0015);
      read_check("dis_byte",  16'h0012, 16'd19);
      bus_write(16'h0010, 16'h0001);
      send_frame(64'h0000_0000_0101_0101, 4, 1'b0);
      idle(3);
      read_check("en_frame", 16'h0011, 16'd6);
      read_check("en_len",   16'h0013, 16'd4);
      read_check("en_byte",  16'h0012, 16'd23);
      read_check("en_runt",  16'h0015, 16'd3);

      // Write to a read-only register is ignored.
      bus_write(16'h0011, 16'h1234);
      read_check("ro_frame", 16'h0011, 16'd6);

      // Clear on the commit edge: counters zero, pulse still seen, enable stays 1.
      done_base = done_cnt;
      send_frame(64'h0000_0000_0000_0707, 2, 1'b1);
      idle(3);
      check("clr_done_pulses", 16'(done_cnt - done_base), 16'd1);
      read_check("clr_frame", 16'h0011, 16'd0);
      read_check("clr_byte",  16'h0012, 16'd0);
      read_check("clr_len",   16'h0013, 16'd0);
      read_check("clr_sum",   16'h0014, 16'd0);
      read_check("clr_runt",  16'h0015, 16'd0);
      read_check("clr_ctrl",  16'h0010, 16'h0001);

      // Reset in the middle of a frame, then a clean 4-byte frame of 0x09 (sum 0x24).
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tx_en = 1'b1; txd = 8'hAA;
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_rd_data", bus_rd_data, 16'h0000);
      check("mid_rst_done", {15'd0, frame_done}, 16'h0000);
      tx_en = 1'b0;
      idle(2);
      rst_n = 1'b1;
      done_base = done_cnt;
      send_frame(64'h0000_0000_0909_0909, 4, 1'b0);
      idle(3);
      check("rst_done_pulses", 16'(done_cnt - done_base), 16'd1);
      read_check("post_rst_frame", 16'h0011, 16'd1);
      read_check("post_rst_len",   16'h0013, 16'd4);
      read_check("post_rst_sum",   16'h0014, 16'h0024);
      read_check("post_rst_byte",  16'h0012, 16'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
